ip_forward_seq: RTL and testbench

Sequencer for one fully-connected layer built on the `ip_forward` dot-product pipeline. On a `start` pulse it walks output neurons 0..num_out-1. For each neuron it reads one weight row from synchronous weight RAM and tags the datapath slot with the neuron index. It tracks in-flight slots with a valid delay line, because the datapath has no valid signal, and buffers results in a result FIFO drained by a valid/ready handshake.

---
 rtl/ip_fwd_seq_pkg.sv | 23 ++
 rtl/ip_result_fifo.sv | 68 ++++++
 rtl/ip_forward_seq.sv | 133 +++++++++++++
 tb/tb_ip_forward_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_fwd_seq_pkg.sv
// Shared types for the ip_forward_seq layer sequencer: FSM states, default tag
// width, result record and the optional negative-clamp helper.
package ip_fwd_seq_pkg;

    localparam int ID_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [31:0]             data;
        logic [ID_W_DEFAULT-1:0] id;
    } result_t;

    function automatic logic [31:0] relu32(input logic [31:0] v);
        return v[31] ? 32'h0 : v;
    endfunction

endpackage

// File: rtl/ip_result_fifo.sv
// Result FIFO with a registered head entry; cnt_o counts every stored entry,
// including the one currently presented on data_o.
module ip_result_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [W-1:0]            push_data_i,
    input  logic                    pop_i,
    output logic                    valid_o,
    output logic [W-1:0]            data_o,
    output logic [$clog2(DEPTH):0]  cnt_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          valid_q;
    logic [W-1:0]  head_q, head_d;
    logic          do_pop;

    assign do_pop = pop_i && valid_q;

    // The head register is reloaded from the entry that becomes oldest, or
    // straight from the push data when the FIFO would otherwise be empty.
    always_comb begin
        rd_d   = rd_q + AW'(do_pop);
        cnt_d  = cnt_q + (AW+1)'(push_i) - (AW+1)'(do_pop);
        head_d = head_q;
        if (cnt_q - (AW+1)'(do_pop) == '0) begin
            if (push_i) head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push_i);
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
            head_q  <= head_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q;
    assign cnt_o   = cnt_q;

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push_i && cnt_q == (AW+1)'(DEPTH)))
        else $error("push into full result FIFO");

endmodule

// File: rtl/ip_forward_seq.sv
// Layer sequencer for the ip_forward dot-product pipeline: issues weight rows, tracks
// in-flight slots, buffers tagged results. Define IP_FWD_SEQ_RELU_EN to zero negatives at push.
module ip_forward_seq
    import ip_fwd_seq_pkg::*;
#(
    parameter int DP_LAT     = 20,
    parameter int FIFO_DEPTH = 32,
    parameter int ID_W       = ID_W_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [ID_W-1:0] num_out,
    output logic            busy,
    output logic            done,
    output logic            w_rd,
    output logic [ID_W-1:0] w_addr,
    output logic [ID_W-1:0] dp_id,
    input  logic [31:0]     dp_out_data,
    input  logic [ID_W-1:0] dp_out_id,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic [ID_W-1:0] out_id,
    output logic            id_err
);
    localparam int CW   = $clog2(DP_LAT + FIFO_DEPTH + 2);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW   = 32 + ID_W;

    seq_state_t      state_q, state_d;
    logic [ID_W-1:0] row_q, row_d, num_q, num_d;
    logic            id_err_q, id_err_d;
    logic [DP_LAT:0] vld_q;
    logic [ID_W-1:0] exp_q [DP_LAT+1];
    logic            issue, push, pop, drain_done;
    logic [CW-1:0]   inflight, credits;
    logic [CNTW-1:0] fifo_cnt;
    logic [31:0]     push_val;
    logic [FW-1:0]   fifo_dout;

    assign push = vld_q[DP_LAT];
    assign pop  = out_valid && out_ready;

`ifdef IP_FWD_SEQ_RELU_EN
    assign push_val = relu32(dp_out_data);
`else
    assign push_val = dp_out_data;
`endif

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < DP_LAT + 1; i++) inflight = inflight + CW'(vld_q[i]);
        credits = inflight + CW'(fifo_cnt);
    end

    // Drained once nothing is in flight and the FIFO empties at this edge.
    assign drain_done = (inflight == '0) &&
                        ((fifo_cnt == '0) || (fifo_cnt == CNTW'(1) && pop));

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        num_d    = num_q;
        id_err_d = id_err_q;
        issue    = 1'b0;
        if (push && dp_out_id != exp_q[DP_LAT]) id_err_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d    = num_out;
                    row_d    = '0;
                    id_err_d = 1'b0;
                    // An empty job passes through DRAIN so done keeps its usual offset.
                    state_d  = (num_out == '0) ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credits < CW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    row_d = row_q + ID_W'(1);
                    if (row_q == num_q - ID_W'(1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (drain_done) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            row_q    <= '0;
            num_q    <= '0;
            id_err_q <= 1'b0;
            vld_q    <= '0;
            for (int unsigned i = 0; i < DP_LAT + 1; i++) exp_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            num_q    <= num_d;
            id_err_q <= id_err_d;
            vld_q    <= {vld_q[DP_LAT-1:0], issue};
            if (issue) exp_q[0] <= row_q;
            for (int unsigned i = 1; i < DP_LAT + 1; i++) exp_q[i] <= exp_q[i-1];
        end
    end

    ip_result_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({push_val, dp_out_id}),
        .pop_i       (out_ready),
        .valid_o     (out_valid),
        .data_o      (fifo_dout),
        .cnt_o       (fifo_cnt)
    );

    assign busy     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign w_rd     = issue;
    assign w_addr   = row_q;
    assign dp_id    = exp_q[0];
    assign id_err   = id_err_q;
    assign out_data = fifo_dout[FW-1:ID_W];
    assign out_id   = fifo_dout[ID_W-1:0];

endmodule

// File: tb/tb_ip_forward_seq.sv
// Bench for ip_forward_seq: datapath stand-in with fixed latency, per-job expected
// stream built from the neuron index range and the per-neuron result table.
module tb_ip_forward_seq;
    localparam int LAT   = 20;
    localparam int DEPTH = 32;
    localparam int IW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] num_out = '0;
    logic          out_ready = 1'b0;
    logic          busy, done, w_rd, out_valid, id_err;
    logic [IW-1:0] w_addr, dp_id, dp_out_id, out_id;
    logic [31:0]   dp_out_data, out_data;

    int n_checks = 0;
    int n_fail   = 0;

    ip_forward_seq #(
        .DP_LAT     (LAT),
        .FIFO_DEPTH (DEPTH),
        .ID_W       (IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_out     (num_out),
        .busy        (busy),
        .done        (done),
        .w_rd        (w_rd),
        .w_addr      (w_addr),
        .dp_id       (dp_id),
        .dp_out_data (dp_out_data),
        .dp_out_id   (dp_out_id),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .id_err      (id_err)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: result for neuron k is datamap[k], LAT cycles after dp_id.
    logic [31:0]   datamap [256];
    logic          corrupt = 1'b0;
    logic [31:0]   pd [LAT];
    logic [IW-1:0] pi [LAT];

    always @(posedge clk) begin
        pd[0] <= datamap[dp_id];
        pi[0] <= dp_id;
        for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            pi[i] <= pi[i-1];
        end
    end
    assign dp_out_data = pd[LAT-1];
    assign dp_out_id   = (corrupt && pi[LAT-1] == 8'd2) ? (pi[LAT-1] ^ 8'h80) : pi[LAT-1];

    function automatic logic [31:0] expd(input logic [31:0] v);
`ifdef IP_FWD_SEQ_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-job observations
    int            nwr, ndone, busy_cnt, done_cyc, first_valid, wr_in_hold, wr_late;
    logic          busy_at_done, err_c1;
    int            wr_cyc[$];
    int            pop_cyc[$];
    logic [IW-1:0] wr_addr[$];
    logic [IW-1:0] pop_id[$];
    logic [31:0]   pop_data[$];

    task automatic run_job(input int n, input int ready_pct, input int hold);
        nwr = 0; ndone = 0; busy_cnt = 0; done_cyc = -1; first_valid = -1;
        wr_in_hold = 0; wr_late = 0; busy_at_done = 1'bx; err_c1 = 1'bx;
        wr_cyc.delete(); pop_cyc.delete(); wr_addr.delete(); pop_id.delete(); pop_data.delete();
        for (int c = 0; c < 3000; c++) begin
            start     = (c == 0);
            num_out   = IW'(n);
            out_ready = (c < hold) ? 1'b0 : ($urandom_range(99) < ready_pct);
            if (busy) busy_cnt++;
            if (c == 1) err_c1 = id_err;
            if (w_rd) begin
                nwr++;
                wr_cyc.push_back(c);
                wr_addr.push_back(w_addr);
                if (c < hold) wr_in_hold++;
                if (c >= 40 && c < hold) wr_late++;
            end
            if (out_valid && first_valid < 0) first_valid = c;
            if (out_valid && out_ready) begin
                pop_cyc.push_back(c);
                pop_id.push_back(out_id);
                pop_data.push_back(out_data);
            end
            if (done) begin
                ndone++;
                done_cyc = c;
                busy_at_done = busy;
            end
            @(negedge clk);
            if (done_cyc >= 0) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_stream(input int n, input int bad);
        chk("wr_count", nwr, n);
        chk("pop_count", pop_id.size(), n);
        chk("done_pulses", ndone, 1);
        for (int k = 0; k < n; k++) begin
            if (k < wr_addr.size()) chk("w_addr", wr_addr[k], k);
            if (k < pop_id.size()) begin
                chk("out_id", pop_id[k], (k == bad) ? (k ^ 'h80) : k);
                chk("out_data", pop_data[k], expd(datamap[k]));
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) datamap[i] = $urandom;
    endtask

    initial begin
        int vcnt, bcnt;
        fill_random();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_rd", w_rd, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_id_err", id_err, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_dp_id", dp_id, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Four neurons, always ready: exact cycle positions
        run_job(4, 100, 0);
        check_stream(4, -1);
        for (int k = 0; k < 4; k++) begin
            if (k < wr_cyc.size())  chk("w_rd_cycle", wr_cyc[k], k + 1);
            if (k < pop_cyc.size()) chk("pop_cycle", pop_cyc[k], LAT + 3 + k);
        end
        chk("first_valid", first_valid, LAT + 3);
        chk("done_cycle", done_cyc, LAT + 7);
        chk("busy_cycles", busy_cnt, LAT + 6);
        chk("busy_at_done", busy_at_done, 0);
        repeat (3) @(negedge clk);

        // Empty job
        run_job(0, 100, 0);
        check_stream(0, -1);
        chk("zero_done_cycle", done_cyc, 2);
        chk("zero_busy_cycles", busy_cnt, 1);
        repeat (3) @(negedge clk);

        // Back-pressure: issue stops once every FIFO slot is committed
        fill_random();
        run_job(40, 100, 80);
        chk("hold_w_rd", wr_in_hold, DEPTH);
        chk("hold_w_rd_late", wr_late, 0);
        check_stream(40, -1);
        repeat (3) @(negedge clk);

        // Tag corruption on neuron 2: flagged, data still delivered
        fill_random();
        corrupt = 1'b1;
        run_job(5, 70, 0);
        check_stream(5, 2);
        chk("id_err_set", id_err, 1);
        corrupt = 1'b0;
        repeat (3) @(negedge clk);
        chk("id_err_sticky", id_err, 1);

        // Next start clears the flag
        run_job(6, 100, 0);
        check_stream(6, -1);
        chk("id_err_cleared_c1", err_c1, 0);
        chk("id_err_end", id_err, 0);
        repeat (3) @(negedge clk);

        // Sign handling of negative, positive and negative-zero results
        fill_random();
        datamap[0] = 32'hBF800000;
        datamap[1] = 32'h3F800000;
        datamap[2] = 32'h80000000;
        datamap[3] = 32'h7FFFFFFF;
        run_job(4, 100, 0);
        check_stream(4, -1);
        repeat (3) @(negedge clk);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            int n, pct;
            fill_random();
            n   = $urandom_range(60, 1);
            pct = $urandom_range(100, 20);
            run_job(n, pct, 0);
            check_stream(n, -1);
            repeat ($urandom_range(4, 1)) @(negedge clk);
        end

        // Reset in the middle of a 16-neuron job
        fill_random();
        start = 1'b1; num_out = 8'd16; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_w_rd", w_rd, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_id_err", id_err, 0);
        chk("mid_w_addr", w_addr, 0);
        chk("mid_dp_id", dp_id, 0);
        chk("mid_out_id", out_id, 0);
        chk("mid_out_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        vcnt = 0; bcnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (out_valid) vcnt++;
            if (busy || w_rd) bcnt++;
            @(negedge clk);
        end
        chk("post_reset_valid", vcnt, 0);
        chk("post_reset_busy", bcnt, 0);
        out_ready = 1'b0;

        // Recovery after reset
        run_job(3, 100, 0);
        check_stream(3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
